// File: rtl/counter_seq_monitor.sv
// Sequence checker for the 3-bit binary/Gray mode counter: predicts each next
// value, flags mismatches, tallies good steps and errors, and latches a sticky fault.
module counter_seq_monitor #(
   parameter int unsigned MAX_ERR = 4,
   parameter int unsigned ERR_W   = 8,
   parameter int unsigned STEP_W  = 16
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              mode,
   input  logic [2:0]        count,
   input  logic              dut_reset,
   output logic              locked,
   output logic              error,
   output logic              fault,
   output logic [2:0]        expected,
   output logic [2:0]        last_bad,
   output logic [ERR_W-1:0]  err_cnt,
   output logic [STEP_W-1:0] step_cnt
);

   localparam int unsigned CNT_W  = 3;
   localparam int unsigned MISS_W = 4;

   typedef enum logic [1:0] {
      ACQ   = 2'd0,
      TRACK = 2'd1,
      FAULT = 2'd2
   } state_t;

   state_t              state, state_nx;
   logic [MISS_W-1:0]   miss, miss_nx;
   logic                locked_nx, error_nx, fault_nx;
   logic [CNT_W-1:0]    expected_nx, last_bad_nx;
   logic [ERR_W-1:0]    err_cnt_nx;
   logic [STEP_W-1:0]   step_cnt_nx;

   // Successor of c under mode m: binary increment or the 3-bit Gray cycle.
   function automatic logic [CNT_W-1:0] next_val(input logic [CNT_W-1:0] c, input logic m);
      logic [CNT_W-1:0] n;
      if (!m) begin
         n = c + CNT_W'(1);
      end else begin
         case (c)
            3'b000:  n = 3'b001;
            3'b001:  n = 3'b011;
            3'b011:  n = 3'b010;
            3'b010:  n = 3'b110;
            3'b110:  n = 3'b111;
            3'b111:  n = 3'b101;
            3'b101:  n = 3'b100;
            default: n = 3'b000;
         endcase
      end
      return n;
   endfunction

   // State register and registered outputs.
   always_ff @(posedge clk) begin
      if (!reset) begin
         state    <= ACQ;
         miss     <= '0;
         locked   <= 1'b0;
         error    <= 1'b0;
         fault    <= 1'b0;
         expected <= '0;
         last_bad <= '0;
         err_cnt  <= '0;
         step_cnt <= '0;
      end else begin
         state    <= state_nx;
         miss     <= miss_nx;
         locked   <= locked_nx;
         error    <= error_nx;
         fault    <= fault_nx;
         expected <= expected_nx;
         last_bad <= last_bad_nx;
         err_cnt  <= err_cnt_nx;
         step_cnt <= step_cnt_nx;
      end
   end

   // Next state and next output values; expected always tracks the sampled count/mode.
   always_comb begin
      state_nx    = state;
      miss_nx     = miss;
      error_nx    = 1'b0;
      expected_nx = next_val(count, mode);
      last_bad_nx = last_bad;
      err_cnt_nx  = err_cnt;
      step_cnt_nx = step_cnt;

      case (state)
         ACQ: begin
            if (dut_reset) begin
               miss_nx = '0;
            end else begin
               state_nx = TRACK;
            end
         end
         TRACK: begin
            if (dut_reset) begin
               state_nx = ACQ;
               miss_nx  = '0;
            end else if (count == expected) begin
               miss_nx = '0;
               if (step_cnt != '1) step_cnt_nx = step_cnt + STEP_W'(1);
            end else begin
               error_nx    = 1'b1;
               last_bad_nx = count;
               miss_nx     = miss + MISS_W'(1);
               if (err_cnt != '1) err_cnt_nx = err_cnt + ERR_W'(1);
               if (miss == MISS_W'(MAX_ERR - 1)) state_nx = FAULT;
            end
         end
         FAULT: begin
            state_nx = FAULT;
         end
         default: begin
            state_nx = ACQ;
            miss_nx  = '0;
         end
      endcase

      locked_nx = (state_nx == TRACK);
      fault_nx  = (state_nx == FAULT);
   end

endmodule

// File: doc/counter_seq_monitor.md
# counter_seq_monitor

Sequence checker for the team's 3-bit mode-controlled counter (counter_d / counter_jk). It sits on the counter's `count`, `mode` and counter-reset nets and checks every clock-to-clock transition against the defined sequence. It reports per-transition errors, keeps good-step and error tallies, and latches a sticky fault after repeated consecutive mismatches. It is the consuming side of the counter interface and is used in benches and as an on-chip self-check.

## Interface
- `MAX_ERR`, default 4: consecutive mismatches that force FAULT; legal range 1..15.
- `ERR_W`, default 8: width of `err_cnt`.
- `STEP_W`, default 16: width of `step_cnt`.
- `clk`, input, 1: single clock; all logic on the rising edge.
- `reset`, input, 1: synchronous, active-low; one clock, reset is synchronous and active-low.
- `mode`, input, 1: counter mode. 0 = binary up; 1 = Gray up.
- `count`, input, 3: observed counter value.
- `dut_reset`, input, 1: counter's own reset, active-high, observed only.
- `locked`, output, 1: high in TRACK.
- `error`, output, 1: one-cycle pulse per mismatched transition.
- `fault`, output, 1: sticky; high in FAULT.
- `expected`, output, 3: value predicted for the current cycle. Meaningful only when `locked`.
- `last_bad`, output, 3: `count` captured on the most recent mismatch.
- `err_cnt`, output, ERR_W: total mismatches; saturates at all-ones.
- `step_cnt`, output, STEP_W: total correct transitions; saturates at all-ones.

## Operation
- Next-value function f(c, m):
  - m=0: (c+1) mod 8.
  - m=1: Gray cycle 000→001→011→010→110→111→101→100→000.
- `prev_count` and `prev_mode` register `count` and `mode` on every edge, in every state including FAULT. After each edge, `expected` = f(prev_count, prev_mode).
- A mode change between samples is legal. The check always uses the mode sampled together with the previous count.
- States:
  - ACQ: no comparison. At the next edge go to TRACK if `dut_reset`=0, else stay in ACQ.
  - TRACK: compare `count` with `expected` at each edge.
    - Match: `step_cnt`+1, consecutive-miss counter cleared.
    - Mismatch: `error`=1 for one cycle, `err_cnt`+1, `last_bad`←`count`, consecutive-miss +1. The reference resyncs automatically through `prev_count`.
    - When consecutive-miss reaches MAX_ERR, go to FAULT at that edge.
  - FAULT: no comparisons, counters frozen, `fault`=1. Left only by `reset`.
- `dut_reset` sampled high in ACQ or TRACK: that edge performs no comparison and the next state is ACQ. Consecutive-miss is cleared. `dut_reset` has no effect in FAULT.
- `reset` sampled low has priority over everything:
  - state ← ACQ.
  - `prev_count`, `prev_mode`, consecutive-miss ← 0.
  - All outputs ← 0: `locked`=0, `error`=0, `fault`=0, `expected`=0, `last_bad`=0, `err_cnt`=0, `step_cnt`=0.
- Saturation: a counter at all-ones holds its value; there is no wrap.

## Timing
- All outputs are registered. A value present on `count` before edge k is judged at edge k.
- `error`, `err_cnt`, `step_cnt` and `last_bad` update directly after edge k (latency 1 edge from sampling).
- First comparison after `reset` release or `dut_reset` deassertion: the second edge with `dut_reset`=0 and `reset`=1. The first such edge is the ACQ capture.
- `locked` rises after the ACQ→TRACK edge. It falls after the edge that enters ACQ or FAULT.
- `error` pulses in back-to-back cycles for consecutive mismatches. The MAX_ERR-th mismatch pulses `error` and raises `fault` in the same cycle.
- Mismatch and `dut_reset` at the same edge: `dut_reset` wins, so there is no `error` and no count update.

## Test plan
- Binary run: `mode`=0, `count` steps 0..7,0,1 on consecutive edges after lock → `error` never high; `step_cnt`=9 after the final sample.
- Gray run with mode switch: binary 5,6,7,0,1,2,3, then `mode`=1 sampled with 3, then 2,6,7,5,4,0 → no `error`; `expected` after the 3-sample is 2.
- Single glitch: binary 2,3,6,7 → one `error` pulse on the 6 sample, `last_bad`=6, `err_cnt`=1. The 7 is accepted (resync), consecutive-miss cleared.
- Fault: MAX_ERR=4, constant `count`=5, `mode`=0 in TRACK → `error` on 4 successive edges, `fault`=1 with the 4th, `err_cnt`=4 and frozen. Further bad data leaves the counts unchanged. `dut_reset` does not clear `fault`; `reset` low for one edge clears all outputs to 0.
- Counter reset mid-run: binary at 4, `dut_reset`=1 for 2 edges with `count`=0, then 1,2 → no `error`. `locked` low during ACQ. The 1 is the capture; the 2 is the first compare and counts as a good step.
- Saturation: ERR_W=2, alternating wrong/right binary values with MAX_ERR=15 → `err_cnt` sticks at 3, `error` still pulses on each mismatch.
